uart_rx: RTL and testbench

- 8N1 UART receiver, the receive-side counterpart of the team's UART transmitter in the same TinyTapeout tile.
- Oversamples the asynchronous serial line using a clock-divided bit timer and validates the start and stop bits.
- Delivers each received byte through a valid/ready handshake.
- Flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync.sv | 29 ++
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
// Contents:
//   uart_state_t          receiver FSM state encoding
//   DATA_BITS             payload bits per frame (8N1)
//   DEFAULT_CLKS_PER_BIT  baud divisor shared by transmitter and receiver
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - multi-flop synchronizer for an asynchronous input
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset; loads RESET_VAL into every stage
//   d    asynchronous input
//   q    synchronized output
module uart_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready output and sticky errors
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rx         asynchronous serial line, idles high
//   data       received byte, stable while valid
//   valid      data holds an unconsumed byte
//   ready      consumer takes data on valid && ready
//   frame_err  sticky, stop bit sampled low
//   overrun    sticky, byte completed while previous byte unconsumed
//   err_clr    clears frame_err and overrun
//   busy       receiver is inside a frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clr,
    output logic                 busy
);

    localparam int TW    = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [TW-1:0]    T_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]    T_HALF   = TW'((CLKS_PER_BIT / 2) - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    uart_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    uart_state_t          state, state_next;
    logic [TW-1:0]        timer, timer_next;
    logic [IDX_W-1:0]     bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 commit;
    logic                 frame_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

    always_comb begin
        state_next   = state;
        timer_next   = timer + TW'(1);
        bit_idx_next = bit_idx;
        shift_next   = shift;
        commit       = 1'b0;
        frame_set    = 1'b0;

        case (state)
            IDLE: begin
                timer_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                // Re-check the line half a bit in; a high here was a glitch.
                if (timer == T_HALF) begin
                    if (!rx_s) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (timer == T_LAST) begin
                    shift_next[bit_idx] = rx_s;
                    timer_next          = '0;
                    if (bit_idx == LAST_BIT) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                // Leaving at mid stop bit lets a back-to-back start edge be seen from IDLE.
                if (timer == T_LAST) begin
                    state_next = IDLE;
                    if (rx_s) begin
                        commit = 1'b1;
                    end else begin
                        frame_set = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next != state) begin
            timer_next = '0;
        end
    end

    // Output holding register: a commit always wins over a same-edge consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (commit) begin
            data  <= shift;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    // Sticky flags: a set on the same edge as err_clr takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end

            if (commit && valid && !ready) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;
    logic       busy;

    int n_checks;
    int n_fails;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one full frame starting at a falling clock edge; returns at the
    // falling edge right after the stop bit period.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int budget, output int waited, output logic seen);
        seen   = 1'b0;
        waited = 0;
        for (int i = 0; i < budget; i++) begin
            if (valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            waited++;
        end
        if (!seen && valid) seen = 1'b1;
    endtask

    int   waited;
    logic seen;
    logic saw_busy;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        rx       = 1'b1;
        ready    = 1'b0;
        err_clr  = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_data",      32'(data),      32'h0);
        check("rst_valid",     32'(valid),     32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun",   32'(overrun),   32'h0);
        check("rst_busy",      32'(busy),      32'h0);

        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte 0xA5: frame takes 40 cycles, commit lands right after.
        send_frame(8'hA5, 1'b1);
        wait_valid(8, waited, seen);
        check("a5_valid",     32'(seen),            32'h1);
        check("a5_latency",   32'(40 + waited <= 42), 32'h1);
        check("a5_data",      32'(data),            32'hA5);
        check("a5_frame_err", 32'(frame_err),       32'h0);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("a5_consumed",  32'(valid),           32'h0);
        repeat (4) @(negedge clk);

        // One-cycle glitch on the line.
        saw_busy = 1'b0;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        check("glitch_busy_pulse", 32'(saw_busy),  32'h1);
        check("glitch_idle",       32'(busy),      32'h0);
        check("glitch_valid",      32'(valid),     32'h0);
        check("glitch_frame_err",  32'(frame_err), 32'h0);
        check("glitch_overrun",    32'(overrun),   32'h0);

        // Framing error on 0x3C.
        send_frame(8'h3C, 1'b0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("fe_frame_err", 32'(frame_err), 32'h1);
        check("fe_valid",     32'(valid),     32'h0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("fe_cleared",   32'(frame_err), 32'h0);
        repeat (8) @(negedge clk);

        // Overrun: two frames back-to-back, nothing consumed.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (2) @(negedge clk);
        check("ovr_overrun", 32'(overrun), 32'h1);
        check("ovr_data",    32'(data),    32'h22);
        check("ovr_valid",   32'(valid),   32'h1);
        ready   = 1'b1;
        err_clr = 1'b1;
        @(negedge clk);
        ready   = 1'b0;
        err_clr = 1'b0;
        check("ovr_clr_valid",   32'(valid),   32'h0);
        check("ovr_clr_overrun", 32'(overrun), 32'h0);
        repeat (4) @(negedge clk);

        // Consume on the very edge that commits the second byte.
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("sim_valid",   32'(valid),   32'h1);
        check("sim_data",    32'(data),    32'h44);
        check("sim_overrun", 32'(overrun), 32'h0);

        // Reset during data bit 3 of 0xFF while a byte is still held.
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB + 2) @(negedge clk);
        check("mid_busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_data",      32'(data),      32'h0);
        check("mid_rst_valid",     32'(valid),     32'h0);
        check("mid_rst_busy",      32'(busy),      32'h0);
        check("mid_rst_frame_err", 32'(frame_err), 32'h0);
        check("mid_rst_overrun",   32'(overrun),   32'h0);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (4 * CPB) @(negedge clk);

        send_frame(8'h5A, 1'b1);
        wait_valid(8, waited, seen);
        check("5a_valid",     32'(seen),      32'h1);
        check("5a_data",      32'(data),      32'h5A);
        check("5a_frame_err", 32'(frame_err), 32'h0);
        check("5a_overrun",   32'(overrun),   32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
